// File: rtl/boron_decrypt_core.sv
// rtl/boron_decrypt_core.sv - iterative BORON-64/80 decryption core (inverse rounds, backward key schedule)
// Optional build macro: BORON_DEC_KEY_CACHE_EN keeps the last master key's final round key to skip expansion.
module boron_decrypt_core #(
  parameter int ROUNDS = 25,
  parameter int KEY_W  = 80
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [63:0]      cipher_i,
  input  logic [KEY_W-1:0] key_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             valid_o,
  output logic [63:0]      data_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_KEXP   = 3'd1;
  localparam logic [2:0] S_WHITEN = 3'd2;
  localparam logic [2:0] S_DEC    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [4:0]  LAST_C = 5'(ROUNDS - 1);
  localparam logic [4:0]  RND_C  = 5'(ROUNDS);
  // Nibble i of each table holds S(i) / S_inv(i).
  localparam logic [63:0] SBOX_TBL = 64'h6358_F02D_AC97_1B4E;
  localparam logic [63:0] SINV_TBL = 64'hB086_275C_4FD1_E93A;

  function automatic logic [15:0] ror16(input logic [15:0] x, input int r);
    return (x >> r) | (x << (16 - r));
  endfunction

  function automatic logic [79:0] ks(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] t;
    t = {k[66:0], k[79:67]};
    t[3:0] = SBOX_TBL[{t[3:0], 2'b00} +: 4];
    t[63:59] = t[63:59] ^ rc;
    return t;
  endfunction

  function automatic logic [79:0] ks_inv(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] t;
    t = k;
    t[63:59] = t[63:59] ^ rc;
    t[3:0] = SINV_TBL[{t[3:0], 2'b00} +: 4];
    return {t[12:0], t[79:13]};
  endfunction

  // Undo, in reverse order: word XOR mixing, per-word rotations, word shuffle, S-layer, key add.
  function automatic logic [63:0] inv_round(input logic [63:0] s, input logic [63:0] k);
    logic [15:0] w0, w1, w2, w3;
    logic [63:0] t;
    w0 = s[15:0];  w1 = s[31:16];  w2 = s[47:32];  w3 = s[63:48];
    w2 = w2 ^ w1;
    w0 = w0 ^ w3;
    w3 = w3 ^ w2;
    w1 = w1 ^ w0;
    w0 = ror16(w0, 1);
    w1 = ror16(w1, 4);
    w2 = ror16(w2, 7);
    w3 = ror16(w3, 9);
    t = {w1, w3, w0, w2};
    for (int n = 0; n < 16; n++) begin
      t[4*n +: 4] = SINV_TBL[{t[4*n +: 4], 2'b00} +: 4];
    end
    return t ^ k;
  endfunction

  logic [2:0]  state_q, state_d;
  logic [63:0] st_q, st_d;
  logic [79:0] kr_q, kr_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] data_q, data_d;
  logic [79:0] kp;
  logic [63:0] st_nx;
  logic        accept;

`ifdef BORON_DEC_KEY_CACHE_EN
  logic [79:0] ck_key_q, ck_key_d;
  logic [79:0] ck_kr_q, ck_kr_d;
  logic        ck_vld_q, ck_vld_d;
`endif

  assign ready_o = (state_q == S_IDLE) || (state_q == S_DONE);
  assign busy_o  = (state_q == S_KEXP) || (state_q == S_WHITEN) || (state_q == S_DEC);
  assign valid_o = (state_q == S_DONE);
  assign data_o  = data_q;
  assign accept  = start_i && ready_o;

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    kr_d    = kr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    kp      = ks_inv(kr_q, cnt_q);
    st_nx   = inv_round(st_q, kp[63:0]);
`ifdef BORON_DEC_KEY_CACHE_EN
    ck_key_d = ck_key_q;
    ck_kr_d  = ck_kr_q;
    ck_vld_d = ck_vld_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          st_d    = cipher_i;
          kr_d    = key_i;
          cnt_d   = 5'd0;
          state_d = S_KEXP;
`ifdef BORON_DEC_KEY_CACHE_EN
          if (ck_vld_q && (ck_key_q == key_i)) begin
            kr_d    = ck_kr_q;
            state_d = S_WHITEN;
          end else begin
            ck_key_d = key_i;
            ck_vld_d = 1'b0;
          end
`endif
        end
      end
      S_KEXP: begin
        kr_d  = ks(kr_q, cnt_q + 5'd1);
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST_C) begin
          state_d = S_WHITEN;
`ifdef BORON_DEC_KEY_CACHE_EN
          ck_kr_d  = kr_d;
          ck_vld_d = 1'b1;
`endif
        end
      end
      S_WHITEN: begin
        st_d    = st_q ^ kr_q[63:0];
        cnt_d   = RND_C;
        state_d = S_DEC;
      end
      S_DEC: begin
        st_d  = st_nx;
        kr_d  = kp;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = S_DONE;
          data_d  = st_nx;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      st_q    <= '0;
      kr_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      kr_q    <= kr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

`ifdef BORON_DEC_KEY_CACHE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ck_key_q <= '0;
      ck_kr_q  <= '0;
      ck_vld_q <= 1'b0;
    end else begin
      ck_key_q <= ck_key_d;
      ck_kr_q  <= ck_kr_d;
      ck_vld_q <= ck_vld_d;
    end
  end
`endif

endmodule

// File: tb/tb_boron_decrypt_core.sv
// tb/tb_boron_decrypt_core.sv - randomized self-checking bench against a forward BORON encryption model
module tb_boron_decrypt_core;

  localparam int R        = 25;
  localparam int LAT_FULL = 2 * R + 1;
  localparam int LAT_HIT  = R + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [63:0] cipher_i;
  logic [79:0] key_i;
  logic        ready_o, busy_o, valid_o;
  logic [63:0] data_o;

  int checks = 0;
  int errors = 0;

  logic [3:0] SB [16] = '{4'hE, 4'h4, 4'hB, 4'h1, 4'h7, 4'h9, 4'hC, 4'hA,
                          4'hD, 4'h2, 4'h0, 4'hF, 4'h8, 4'h5, 4'h3, 4'h6};

  logic [79:0] m_key = '0;
  bit          m_vld = 1'b0;

  boron_decrypt_core #(.ROUNDS(R), .KEY_W(80)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .cipher_i(cipher_i), .key_i(key_i),
    .ready_o(ready_o), .busy_o(busy_o), .valid_o(valid_o), .data_o(data_o)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rol16(input logic [15:0] x, input int r);
    return (x << r) | (x >> (16 - r));
  endfunction

  function automatic logic [63:0] enc(input logic [63:0] p, input logic [79:0] k);
    logic [63:0] s;
    logic [79:0] kk;
    logic [15:0] w [4];
    logic [15:0] o [4];
    s  = p;
    kk = k;
    for (int r = 1; r <= R; r++) begin
      s = s ^ kk[63:0];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = SB[s[4*n +: 4]];
      for (int i = 0; i < 4; i++) w[i] = s[16*i +: 16];
      o[3] = w[2]; o[2] = w[0]; o[1] = w[3]; o[0] = w[1];
      o[0] = rol16(o[0], 1); o[1] = rol16(o[1], 4);
      o[2] = rol16(o[2], 7); o[3] = rol16(o[3], 9);
      o[1] ^= o[0]; o[3] ^= o[2]; o[0] ^= o[3]; o[2] ^= o[1];
      s  = {o[3], o[2], o[1], o[0]};
      kk = {kk[66:0], kk[79:67]};
      kk[3:0] = SB[kk[3:0]];
      kk[63:59] = kk[63:59] ^ 5'(r);
    end
    return s ^ kk[63:0];
  endfunction

  function automatic int exp_lat(input logic [79:0] k);
    bit hit;
    hit = m_vld && (m_key == k);
`ifdef BORON_DEC_KEY_CACHE_EN
    if (hit) return LAT_HIT;
`endif
    return hit ? LAT_FULL : LAT_FULL;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_req(input logic [63:0] c, input logic [79:0] k, output int lat);
    int n;
    n = 0;
    while (!ready_o && n < 200) begin tick; n++; end
    cipher_i = c; key_i = k; start_i = 1'b1;
    tick;
    start_i = 1'b0;
    lat = 0;
    while (!valid_o && lat < 200) begin tick; lat++; end
  endtask

  task automatic test_reset;
    rst = 1'b1; start_i = 1'b0; cipher_i = '0; key_i = '0;
    tick; tick;
    rst = 1'b0;
    #1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_o); end
    checks++; if (data_o !== 64'h0) begin errors++; $display("FAIL reset_data got %h want 0", data_o); end
  endtask

  task automatic test_zero;
    int lat, el;
    el = exp_lat(80'h0);
    run_req(enc(64'h0, 80'h0), 80'h0, lat);
    m_key = 80'h0; m_vld = 1'b1;
    checks++; if (lat !== el) begin errors++; $display("FAIL zero_latency got %0d want %0d", lat, el); end
    checks++; if (data_o !== 64'h0) begin errors++; $display("FAIL zero_data got %h want 0", data_o); end
    tick;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL zero_pulse got %b want 0", valid_o); end
  endtask

  task automatic test_ones;
    int lat, el;
    logic [79:0] k;
    logic [63:0] p;
    k = {80{1'b1}}; p = {64{1'b1}};
    el = exp_lat(k);
    run_req(enc(p, k), k, lat);
    m_key = k; m_vld = 1'b1;
    checks++; if (lat !== el) begin errors++; $display("FAIL ones_latency got %0d want %0d", lat, el); end
    checks++; if (data_o !== p) begin errors++; $display("FAIL ones_data got %h want %h", data_o, p); end
    checks++; if (dut.kr_q !== k) begin errors++; $display("FAIL ones_kr got %h want %h", dut.kr_q, k); end
  endtask

  task automatic test_random;
    int lat, el;
    logic [79:0] k;
    logic [63:0] p;
    k = '0;
    for (int it = 0; it < 1000; it++) begin
      p = {$urandom, $urandom};
      if (it == 0 || $urandom_range(3) != 0) k = {$urandom_range(16'hFFFF), $urandom, $urandom};
      el = exp_lat(k);
      run_req(enc(p, k), k, lat);
      m_key = k; m_vld = 1'b1;
      checks++; if (lat !== el) begin errors++; $display("FAIL rand_latency it %0d got %0d want %0d", it, lat, el); end
      checks++; if (data_o !== p) begin errors++; $display("FAIL rand_data it %0d got %h want %h", it, data_o, p); end
      checks++; if (dut.kr_q !== k) begin errors++; $display("FAIL rand_kr it %0d got %h want %h", it, dut.kr_q, k); end
      tick;
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rand_pulse it %0d got %b want 0", it, valid_o); end
    end
  endtask

  task automatic test_key_reuse;
    int lat;
    logic [79:0] k1, k2;
    logic [63:0] p;
    k1 = {16'h1234, $urandom, $urandom};
    k2 = ~k1;
    p = {$urandom, $urandom};
    run_req(enc(p, k1), k1, lat);
    m_key = k1; m_vld = 1'b1;
    p = {$urandom, $urandom};
`ifdef BORON_DEC_KEY_CACHE_EN
    run_req(enc(p, k1), k1, lat);
    checks++; if (lat !== LAT_HIT) begin errors++; $display("FAIL reuse_latency got %0d want %0d", lat, LAT_HIT); end
`else
    run_req(enc(p, k1), k1, lat);
    checks++; if (lat !== LAT_FULL) begin errors++; $display("FAIL reuse_latency got %0d want %0d", lat, LAT_FULL); end
`endif
    checks++; if (data_o !== p) begin errors++; $display("FAIL reuse_data got %h want %h", data_o, p); end
    p = {$urandom, $urandom};
    run_req(enc(p, k2), k2, lat);
    m_key = k2; m_vld = 1'b1;
    checks++; if (lat !== LAT_FULL) begin errors++; $display("FAIL newkey_latency got %0d want %0d", lat, LAT_FULL); end
    checks++; if (data_o !== p) begin errors++; $display("FAIL newkey_data got %h want %h", data_o, p); end
  endtask

  task automatic test_reset_mid;
    int lat, seen;
    logic [79:0] k;
    logic [63:0] p;
    k = {16'hA5A5, $urandom, $urandom}; p = {$urandom, $urandom};
    while (!ready_o) tick;
    cipher_i = enc(p, k); key_i = k; start_i = 1'b1;
    tick;
    start_i = 1'b0;
    repeat (30) tick;
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b want 1", busy_o); end
    #2 rst = 1'b1;
    #1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL mid_ready got %b want 1", ready_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", busy_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", valid_o); end
    checks++; if (data_o !== 64'h0) begin errors++; $display("FAIL mid_data got %h want 0", data_o); end
    tick;
    rst = 1'b0;
    m_vld = 1'b0;
    seen = 0;
    repeat (80) begin tick; if (valid_o) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL mid_no_valid got %0d pulses want 0", seen); end
    run_req(enc(p, k), k, lat);
    m_key = k; m_vld = 1'b1;
    checks++; if (lat !== LAT_FULL) begin errors++; $display("FAIL mid_after_latency got %0d want %0d", lat, LAT_FULL); end
    checks++; if (data_o !== p) begin errors++; $display("FAIL mid_after_data got %h want %h", data_o, p); end
  endtask

  task automatic test_back_to_back;
    logic [63:0] p [3];
    logic [79:0] k [3];
    int vt [3];
    int el [3];
    int nv, t;
    for (int i = 0; i < 3; i++) begin
      p[i] = {$urandom, $urandom};
      k[i] = {16'(i + 7), $urandom, $urandom};
      vt[i] = 0;
    end
    while (!ready_o) tick;
    el[0] = exp_lat(k[0]);
    cipher_i = enc(p[0], k[0]); key_i = k[0]; start_i = 1'b1;
    tick;
    nv = 0;
    t = 0;
    while (nv < 3 && t < 400) begin
      tick;
      t++;
      if (valid_o) begin
        vt[nv] = t;
        m_key = k[nv]; m_vld = 1'b1;
        checks++; if (data_o !== p[nv]) begin errors++; $display("FAIL b2b_data req %0d got %h want %h", nv, data_o, p[nv]); end
        nv++;
        if (nv < 3) begin
          el[nv] = exp_lat(k[nv]);
          cipher_i = enc(p[nv], k[nv]); key_i = k[nv];
        end else begin
          start_i = 1'b0;
        end
      end
    end
    start_i = 1'b0;
    checks++; if (nv !== 3) begin errors++; $display("FAIL b2b_count got %0d want 3", nv); end
    checks++; if (vt[0] !== el[0]) begin errors++; $display("FAIL b2b_first got %0d want %0d", vt[0], el[0]); end
    checks++; if (vt[1] - vt[0] !== el[1] + 1) begin errors++; $display("FAIL b2b_gap1 got %0d want %0d", vt[1] - vt[0], el[1] + 1); end
    checks++; if (vt[2] - vt[1] !== el[2] + 1) begin errors++; $display("FAIL b2b_gap2 got %0d want %0d", vt[2] - vt[1], el[2] + 1); end
    tick;
    checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin errors++; $display("FAIL b2b_idle got valid %b ready %b want 0 1", valid_o, ready_o); end
  endtask

  initial begin
    test_reset;
    test_zero;
    test_ones;
    test_reset_mid;
    test_back_to_back;
    test_key_reuse;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
